// File: rtl/axis_pack_ctrl.sv
// axis_pack_ctrl
//   Sequencer for the byte-packing buffer in the FM IP stream path. It takes a
//   sparse-keep AXI-Stream slave and writes each beat into the buffer. It then
//   reads packed words back out and presents them on an AXI-Stream master. At
//   end of packet it flushes the partial tail word with tlast.
//   The buffer exposes only empty/full, so this block tracks the fill level in
//   bytes itself (byte_cnt).
//
//   Parameters
//     DATA_WIDTH : stream/buffer word width, 8/16/32
//     BUF_BYTES  : byte capacity of the buffer, a multiple of DATA_WIDTH/8
//
//   Ports
//     clk, reset_n                : clock, synchronous active-low reset (shared with buffer)
//     s_axis_*                    : slave stream in (tdata/tkeep/tvalid/tlast, tready out)
//     buf_w_en/buf_din/_keep      : buffer write side (pass-through of accepted beats)
//     buf_r_en                    : buffer read strobe; dout/dout_keep valid next cycle, held
//     buf_dout/_keep, empty, full : buffer read side and status
//     m_axis_*                    : master stream out (tvalid/tlast registered)
//     stat_pkt_cnt/stat_byte_cnt  : output packet/byte counters (AXIS_PACK_STATS_EN only)
//
//   Configuration
//     AXIS_PACK_STATS_EN : when defined, adds the stat_* ports and counters.
module axis_pack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_BYTES  = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      buf_w_en,
  output logic [DATA_WIDTH-1:0]     buf_din,
  output logic [DATA_WIDTH/8-1:0]   buf_din_keep,
  output logic                      buf_r_en,
  input  logic [DATA_WIDTH-1:0]     buf_dout,
  input  logic [DATA_WIDTH/8-1:0]   buf_dout_keep,
  input  logic                      buf_empty,
  input  logic                      buf_full,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
`ifdef AXIS_PACK_STATS_EN
  ,
  output logic [15:0]               stat_pkt_cnt,
  output logic [31:0]               stat_byte_cnt
`endif
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam logic [CW-1:0] KW_C  = CW'(KW);
  localparam logic [CW:0]   KW_X  = (CW+1)'(KW);
  localparam logic [CW:0]   BUF_X = (CW+1)'(BUF_BYTES);

  // Illegal geometry stops elaboration.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) ||
      (BUF_BYTES % KW) != 0 || BUF_BYTES < KW) begin : g_bad_param
    $fatal(1, "axis_pack_ctrl: illegal DATA_WIDTH/BUF_BYTES");
  end

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [CW-1:0]   wr_bytes, rd_bytes;
  logic            rst_done;   // holds tready low through the reset cycle
  logic            wr, rd, out_free, room;

  function automatic logic [CW-1:0] popcnt(input logic [KW-1:0] k);
    popcnt = '0;
    for (int i = 0; i < KW; i++) popcnt = popcnt + CW'(k[i]);
  endfunction

  // Room check assumes a full word so a write can never overflow the buffer.
  assign room          = ({1'b0, byte_cnt} + KW_X) <= BUF_X;
  assign s_axis_tready = rst_done & (state != DRAIN) & ~buf_full & room;
  assign wr            = s_axis_tvalid & s_axis_tready;

  assign buf_w_en      = wr;
  assign buf_din       = s_axis_tdata;
  assign buf_din_keep  = s_axis_tkeep;

  // Only full words leave while filling; the tail goes out in DRAIN, when no
  // write can race it.
  assign out_free = ~m_axis_tvalid | m_axis_tready;
  assign rd       = out_free & (((state == FILL)  & (byte_cnt >= KW_C)) |
                                ((state == DRAIN) & (byte_cnt != '0)));
  assign buf_r_en = rd;

  assign wr_bytes = wr ? popcnt(s_axis_tkeep) : '0;
  assign rd_bytes = rd ? ((byte_cnt < KW_C) ? byte_cnt : KW_C) : '0;

  assign m_axis_tdata = buf_dout;
  assign m_axis_tkeep = buf_dout_keep;

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt + wr_bytes - rd_bytes;
    case (state)
      IDLE: if (wr) begin
        if (s_axis_tlast) state_nxt = (byte_cnt_nxt != '0) ? DRAIN : IDLE;
        else              state_nxt = FILL;
      end
      FILL: if (wr && s_axis_tlast) state_nxt = (byte_cnt_nxt != '0) ? DRAIN : IDLE;
      DRAIN: if (rd && byte_cnt <= KW_C) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      rst_done      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      rst_done <= 1'b1;
      // Single output register, no skid: a read is only issued when it is free.
      m_axis_tvalid <= rd ? 1'b1 : (m_axis_tready ? 1'b0 : m_axis_tvalid);
      if (rd) m_axis_tlast <= (state == DRAIN) && (byte_cnt <= KW_C);
    end
  end

  // Sanity: buffer emptiness must agree with the tracked fill level.
  a_empty_tracks: assert property (@(posedge clk) disable iff (!reset_n)
    buf_empty == (byte_cnt == '0));

`ifdef AXIS_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_pkt_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tlast) stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
      stat_byte_cnt <= stat_byte_cnt + 32'(popcnt(m_axis_tkeep));
    end
  end
`endif

endmodule

// File: tb/tb_axis_pack_ctrl.sv
// Bench for axis_pack_ctrl (DATA_WIDTH=32, BUF_BYTES=16). It contains a
// byte-queue model of the packing buffer and a packet-level expected-output
// queue. A negedge process compares every accepted output beat against that
// queue and checks hold-stability under backpressure. Directed tests pin
// literal values.
module tb_axis_pack_ctrl;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int BB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic          buf_w_en, buf_r_en;
  logic [DW-1:0] buf_din, buf_dout = '0;
  logic [KW-1:0] buf_din_keep, buf_dout_keep = '0;
  logic          buf_empty = 1'b1, buf_full = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
`ifdef AXIS_PACK_STATS_EN
  logic [15:0]   stat_pkt;
  logic [31:0]   stat_bytes;
`endif

  axis_pack_ctrl #(.DATA_WIDTH(DW), .BUF_BYTES(BB)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .buf_w_en(buf_w_en), .buf_din(buf_din), .buf_din_keep(buf_din_keep),
    .buf_r_en(buf_r_en), .buf_dout(buf_dout), .buf_dout_keep(buf_dout_keep),
    .buf_empty(buf_empty), .buf_full(buf_full),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
`ifdef AXIS_PACK_STATS_EN
    , .stat_pkt_cnt(stat_pkt), .stat_byte_cnt(stat_bytes)
`endif
  );

  // Packing buffer: bytes queue in order; a read pops up to KW oldest bytes.
  byte q_buf[$];
  always @(posedge clk) begin
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    if (!reset_n) begin
      q_buf.delete();
      buf_dout      <= '0;
      buf_dout_keep <= '0;
    end else begin
      if (buf_r_en) begin
        d = '0; k = '0;
        for (int i = 0; i < KW; i++)
          if (q_buf.size() > 0) begin d[i*8 +: 8] = q_buf.pop_front(); k[i] = 1'b1; end
        buf_dout      <= d;
        buf_dout_keep <= k;
      end
      if (buf_w_en)
        for (int i = 0; i < KW; i++)
          if (buf_din_keep[i]) q_buf.push_back(buf_din[i*8 +: 8]);
    end
    buf_full  <= (q_buf.size() >= BB);
    buf_empty <= (q_buf.size() == 0);
  end

  typedef struct packed { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;
  beat_t exp_q[$];
  beat_t out_log[$];
  int    out_cyc[$];
  byte   pend[$];
  int    n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] kmask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < KW; i++) if (k[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Move n oldest pending bytes into one expected output word.
  task automatic push_word(input int n, input logic last);
    beat_t b;
    b = '0;
    for (int i = 0; i < n; i++) begin b.d[i*8 +: 8] = pend.pop_front(); b.k[i] = 1'b1; end
    b.l = last;
    exp_q.push_back(b);
  endtask

  // Packet model: bytes are packed in arrival order into KW-byte words;
  // the final word of a packet carries tlast.
  task automatic model_in(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    for (int i = 0; i < KW; i++) if (k[i]) pend.push_back(d[i*8 +: 8]);
    if (l) begin
      while (pend.size() > 0) push_word((pend.size() < KW) ? pend.size() : KW, pend.size() <= KW);
    end else begin
      while (pend.size() >= KW) push_word(KW, 1'b0);
    end
  endtask

  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [KW-1:0] pk = '0;
  always @(negedge clk) begin
    beat_t e, o;
    cyc++;
    if (!reset_n) begin
      exp_q.delete(); pend.delete(); pv = 1'b0;
    end else begin
      chk("w_en", buf_w_en, s_tvalid & s_tready);
      if (pv && !pr) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_beat", {m_tdata, m_tkeep, m_tlast}, {pd, pk, pl});
      end
      if (m_tvalid && !m_tready) chk("no_ren_stalled", buf_r_en, 1'b0);
      if (m_tvalid && m_tready) begin
        o.d = m_tdata & kmask(m_tkeep); o.k = m_tkeep; o.l = m_tlast;
        out_log.push_back(o); out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_extra: got %0h, want no beat", o);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", o.d, e.d);
          chk("out_keep", o.k, e.k);
          chk("out_last", o.l, e.l);
        end
      end
      if (s_tvalid && s_tready) model_in(s_tdata, s_tkeep, s_tlast);
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_tready) break;
      if (t > 200) begin n_cmp++; n_bad++; $display("FAIL send_timeout: got no tready, want tready"); break; end
    end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_quiet();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (!m_tvalid && dut.byte_cnt == 0 && exp_q.size() == 0) break;
      if (t > 300) begin n_cmp++; n_bad++; $display("FAIL drain_timeout: got busy, want idle"); break; end
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc;
    // 1: reset
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_ren", buf_r_en, 1'b0);
    tick();
    chk("rst_tready", s_tready, 1'b1);

    // 2: 3 + 4 bytes -> full word then 3-byte tail with tlast
    m_tready = 1'b1;
    base = out_log.size();
    send(32'h00332211, 4'h7, 1'b0);
    send(32'h77665544, 4'hF, 1'b1);
    wait_quiet();
    chk("t2_beats", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      chk("t2_b0", out_log[base],   {32'h44332211, 4'hF, 1'b0});
      chk("t2_b1", out_log[base+1], {32'h00776655, 4'h7, 1'b1});
    end
    chk("t2_cnt", dut.byte_cnt, 0);
    chk("t2_tready", s_tready, 1'b1);

    // 3: three full beats under 6 cycles of backpressure
    m_tready = 1'b0;
    base = out_log.size();
    send(32'hA3A2A1A0, 4'hF, 1'b0);
    send(32'hB3B2B1B0, 4'hF, 1'b0);
    send(32'hC3C2C1C0, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_pending", m_tvalid, 1'b1);
      chk("t3_data", m_tdata, 32'hA3A2A1A0);
      chk("t3_ren", buf_r_en, 1'b0);
      tick();
    end
    m_tready = 1'b1;
    wait_quiet();
    chk("t3_beats", out_log.size() - base, 3);
    if (out_log.size() >= base + 3) begin
      chk("t3_b2", out_log[base+2], {32'hC3C2C1C0, 4'hF, 1'b1});
      chk("t3_gap01", out_cyc[base+1] - out_cyc[base], 1);
      chk("t3_gap12", out_cyc[base+2] - out_cyc[base+1], 1);
    end

    // 4: buffer capacity 16 bytes, 6 beats offered with no output ready
    m_tready = 1'b0;
    base = out_log.size();
    acc = 0;
    s_tvalid = 1'b1; s_tkeep = 4'hF;
    for (int i = 0; i < 12; i++) begin
      s_tdata = 32'h40404040 + acc; s_tlast = (acc == 5);
      @(negedge clk);
      if (s_tready) acc++;
      tick();
    end
    chk("t4_accepted", acc, 5);
    chk("t4_tready_low", s_tready, 1'b0);
    m_tready = 1'b1;
    for (int t = 0; acc < 6; t++) begin
      s_tdata = 32'h40404040 + acc; s_tlast = (acc == 5);
      @(negedge clk);
      if (s_tready) acc++;
      tick();
      if (t > 100) begin n_cmp++; n_bad++; $display("FAIL t4_timeout: got %0d beats, want 6", acc); break; end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_quiet();
    chk("t4_beats", out_log.size() - base, 6);
    if (out_log.size() >= base + 6)
      chk("t4_b5", out_log[base+5], {32'h40404045, 4'hF, 1'b1});

    // 5: zero-keep beat with tlast produces nothing
    base = out_log.size();
    send(32'hFFFFFFFF, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_tready", s_tready, 1'b1);
      tick();
    end
    chk("t5_beats", out_log.size() - base, 0);
    chk("t5_cnt", dut.byte_cnt, 0);

    // 6: reset during DRAIN of a 7-byte packet, then a clean 4-byte packet
    m_tready = 1'b0;
    send(32'h13121110, 4'hF, 1'b0);
    send(32'h00161514, 4'h7, 1'b1);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_tvalid", m_tvalid, 1'b0);
    chk("t6_cnt", dut.byte_cnt, 0);
    m_tready = 1'b1;
    base = out_log.size();
    send(32'hDEADBEEF, 4'hF, 1'b1);
    wait_quiet();
    chk("t6_beats", out_log.size() - base, 1);
    if (out_log.size() >= base + 1)
      chk("t6_b0", out_log[base], {32'hDEADBEEF, 4'hF, 1'b1});
`ifdef AXIS_PACK_STATS_EN
    chk("t6_stat_pkt", stat_pkt, 1);
    chk("t6_stat_bytes", stat_bytes, 4);
`endif

    chk("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
